// File: rtl/cpu16_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op and state encodings plus the
// op-to-slice control decode.
package cpu16_alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_PASSB = 2'b10,
        ALU_NEGB  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic aen;
        logic binv;
        logic cin0;
    } slice_ctrl_t;

    // Subtraction and negation are a + ~b + 1, so binv and cin0 travel together.
    function automatic slice_ctrl_t decode_op(input logic [1:0] op);
        slice_ctrl_t ctrl;
        case (op)
            ALU_ADD:   ctrl = '{aen: 1'b1, binv: 1'b0, cin0: 1'b0};
            ALU_SUB:   ctrl = '{aen: 1'b1, binv: 1'b1, cin0: 1'b1};
            ALU_PASSB: ctrl = '{aen: 1'b0, binv: 1'b0, cin0: 1'b0};
            ALU_NEGB:  ctrl = '{aen: 1'b0, binv: 1'b1, cin0: 1'b1};
            default:   ctrl = '{aen: 1'b0, binv: 1'b0, cin0: 1'b0};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice: full adder with operand-A enable and operand-B inversion.
module alu1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic aen,
    input  logic binv,
    input  logic reset,
    output logic sum,
    output logic cout
);

    logic a_eff_s;
    logic b_eff_s;

    // Full-adder evaluation; reset forces a quiet slice.
    always_comb begin
        a_eff_s = a & aen;
        b_eff_s = b ^ binv;
        if (reset) begin
            sum  = 1'b0;
            cout = 1'b0;
        end else begin
            sum  = a_eff_s ^ b_eff_s ^ cin;
            cout = (a_eff_s & b_eff_s) | (a_eff_s & cin) | (b_eff_s & cin);
        end
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs one alu1bit slice LSB-first over WIDTH clocks
// and returns the result with carry, overflow and zero flags.
module bit_serial_alu_ctrl
    import cpu16_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_c,
    output logic             rsp_v,
    output logic             rsp_z
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] Y_ZERO   = {WIDTH{1'b0}};

    alu_state_e       state_r;
    alu_state_e       state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] y_sh_r;
    logic [WIDTH-1:0] y_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             aen_r;
    logic             binv_r;
    logic             sum_s;
    logic             cout_s;
    logic             accept_s;
    logic             last_s;
    slice_ctrl_t      ctrl_s;

    alu1bit u_slice (
        .a     (a_sh_r[0]),
        .b     (b_sh_r[0]),
        .cin   (carry_r),
        .aen   (aen_r),
        .binv  (binv_r),
        .reset (1'b0),
        .sum   (sum_s),
        .cout  (cout_s)
    );

    assign ctrl_s   = decode_op(req_op);
    assign accept_s = (state_r == S_IDLE) && req_valid && !flush;
    assign last_s   = (state_r == S_RUN) && (cnt_r == CNT_LAST) && !flush;
    assign y_next_s = {sum_s, y_sh_r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  state_s = req_valid ? S_RUN : S_IDLE;
                S_RUN:   state_s = (cnt_r == CNT_LAST) ? S_DONE : S_RUN;
                S_DONE:  state_s = rsp_ready ? S_IDLE : S_DONE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Handshake flags registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (state_s == S_IDLE);
            rsp_valid <= (state_s == S_DONE);
        end
    end

    // Operand shift registers, carry feedback and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh_r  <= Y_ZERO;
            b_sh_r  <= Y_ZERO;
            y_sh_r  <= Y_ZERO;
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            aen_r   <= 1'b0;
            binv_r  <= 1'b0;
        end else if (accept_s) begin
            a_sh_r  <= req_a;
            b_sh_r  <= req_b;
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= ctrl_s.cin0;
            aen_r   <= ctrl_s.aen;
            binv_r  <= ctrl_s.binv;
        end else if ((state_r == S_RUN) && !flush) begin
            y_sh_r  <= y_next_s;
            a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            carry_r <= cout_s;
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            a_sh_r <= a_sh_r;
        end
    end

    // Response registers load on the final RUN edge so DONE sees stable flags;
    // the carry still held in carry_r at that edge is the carry into the MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_y <= Y_ZERO;
            rsp_c <= 1'b0;
            rsp_v <= 1'b0;
            rsp_z <= 1'b0;
        end else if (last_s) begin
            rsp_y <= y_next_s;
            rsp_c <= cout_s;
            rsp_v <= carry_r ^ cout_s;
            rsp_z <= (y_next_s == Y_ZERO);
        end else begin
            rsp_y <= rsp_y;
        end
    end

endmodule
